// File: rtl/led_array_arbiter.sv
// Round-robin owner arbiter for the shared user LED array.
// Define LED_ARB_TIMEOUT_EN to enable hold-timeout preemption.
module led_array_arbiter #(
   parameter int               NUM_REQ      = 4,
   parameter int               LED_W        = 8,
   parameter int               HOLD_MAX     = 1024,
   parameter logic [LED_W-1:0] IDLE_PATTERN = '0,
   localparam int              OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LED_W-1:0] pattern,
   output logic [NUM_REQ-1:0]       grant,
   output logic [OW-1:0]            owner,
   output logic                     busy,
   output logic                     preempt,
   output logic [LED_W-1:0]         led
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nx;
   logic [OW-1:0]      ptr, ptr_nx;
   logic [OW-1:0]      owner_nx;
   logic [OW-1:0]      win;
   logic [OW-1:0]      cand;
   logic               win_vld;
   logic [NUM_REQ-1:0] grant_nx;
   logic               busy_nx;
   logic [LED_W-1:0]   led_nx;
   logic [LED_W-1:0]   sel;
   logic               release_req;

`ifdef LED_ARB_TIMEOUT_EN
   localparam int            CW       = $clog2(HOLD_MAX);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

   logic [CW-1:0] cnt, cnt_nx;
   logic          preempt_nx;
   logic          timeout;
`endif

   // first requester after the pointer, wrapping around
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((int'(ptr) + i) % NUM_REQ);
         if (!win_vld && req[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   // pattern of the current owner
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner == OW'(i)) sel = pattern[i*LED_W +: LED_W];
      end
   end

   assign release_req = ~|(req & grant);

`ifdef LED_ARB_TIMEOUT_EN
   assign timeout = (cnt == CNT_LAST) && (|(req & ~grant));
`endif

   // next-state and registered-output logic
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      owner_nx = owner;
      busy_nx  = busy;
      ptr_nx   = ptr;
      led_nx   = led;
`ifdef LED_ARB_TIMEOUT_EN
      cnt_nx     = cnt;
      preempt_nx = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            led_nx = IDLE_PATTERN;
            if (win_vld) begin
               grant_nx = NUM_REQ'(1) << win;
               owner_nx = win;
               busy_nx  = 1'b1;
               ptr_nx   = win;
               state_nx = GRANT;
`ifdef LED_ARB_TIMEOUT_EN
               cnt_nx   = '0;
`endif
            end
         end
         GRANT: begin
            led_nx = sel;
            if (release_req) begin
               grant_nx = '0;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
`ifdef LED_ARB_TIMEOUT_EN
            else if (timeout) begin
               grant_nx   = '0;
               busy_nx    = 1'b0;
               preempt_nx = 1'b1;
               state_nx   = IDLE;
            end else if (cnt != CNT_LAST) begin
               cnt_nx = cnt + 1'b1;
            end
`endif
         end
         default: state_nx = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         grant <= '0;
         owner <= '0;
         busy  <= 1'b0;
         ptr   <= OW'(NUM_REQ - 1);
         led   <= IDLE_PATTERN;
      end else begin
         state <= state_nx;
         grant <= grant_nx;
         owner <= owner_nx;
         busy  <= busy_nx;
         ptr   <= ptr_nx;
         led   <= led_nx;
      end
   end

`ifdef LED_ARB_TIMEOUT_EN
   // hold counter and preemption pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         preempt <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         preempt <= preempt_nx;
      end
   end
`else
   assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_led_array_arbiter.sv
// Directed bench for led_array_arbiter.
// Timeout expectations follow LED_ARB_TIMEOUT_EN.
module tb_led_array_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] pattern;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic        preempt;
   logic [7:0]  led;

   int total = 0;
   int bad   = 0;

   led_array_arbiter #(
      .NUM_REQ(4),
      .LED_W(8),
      .HOLD_MAX(8),
      .IDLE_PATTERN(8'h00)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .pattern(pattern),
      .grant(grant),
      .owner(owner),
      .busy(busy),
      .preempt(preempt),
      .led(led)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [3:0] bit_k;
   logic       saw_pre;

   initial begin
      reset   = 1'b0;
      req     = '0;
      pattern = '0;
      repeat (3) tick();
      chk("rst_grant", {28'd0, grant}, 32'h0);
      chk("rst_busy", {31'd0, busy}, 32'h0);
      chk("rst_led", {24'd0, led}, 32'h00);
      chk("rst_owner", {30'd0, owner}, 32'h0);
      chk("rst_pre", {31'd0, preempt}, 32'h0);
      reset = 1'b1;
      tick();
      chk("idle_grant", {28'd0, grant}, 32'h0);

      // single owner
      pattern[2*8 +: 8] = 8'hA5;
      req = 4'b0100;
      tick();
      chk("so_grant", {28'd0, grant}, 32'h4);
      chk("so_owner", {30'd0, owner}, 32'h2);
      chk("so_busy", {31'd0, busy}, 32'h1);
      chk("so_led_t1", {24'd0, led}, 32'h00);
      tick();
      chk("so_led_t2", {24'd0, led}, 32'hA5);
      req = 4'b0000;
      tick();
      chk("so_drop_grant", {28'd0, grant}, 32'h0);
      chk("so_drop_busy", {31'd0, busy}, 32'h0);
      chk("so_drop_led", {24'd0, led}, 32'hA5);
      tick();
      chk("so_idle_led", {24'd0, led}, 32'h00);

      // live pattern, owner 1
      pattern[1*8 +: 8] = 8'h01;
      req = 4'b0010;
      tick();
      chk("lp_grant", {28'd0, grant}, 32'h2);
      tick();
      chk("lp_led_a", {24'd0, led}, 32'h01);
      pattern[1*8 +: 8] = 8'h80;
      tick();
      chk("lp_led_b", {24'd0, led}, 32'h80);

      // async reset mid-grant
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("ar_grant", {28'd0, grant}, 32'h0);
      chk("ar_busy", {31'd0, busy}, 32'h0);
      chk("ar_led", {24'd0, led}, 32'h00);
      @(negedge clk);
      reset = 1'b1;
      req   = 4'b0001;
      tick();
      chk("ar_rel_grant", {28'd0, grant}, 32'h1);

      // round-robin with all requesting
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         bit_k = 4'b0001 << (k % 4);
         chk($sformatf("rr%0d_grant", k), {28'd0, grant}, {28'd0, bit_k});
         chk($sformatf("rr%0d_owner", k), {30'd0, owner}, k % 4);
         tick();
         tick();
         chk($sformatf("rr%0d_hold", k), {28'd0, grant}, {28'd0, bit_k});
         req = req & ~bit_k;
         tick();
         chk($sformatf("rr%0d_gap", k), {28'd0, grant}, 32'h0);
         req = 4'b1111;
         if (k < 4) tick();
      end
      req = 4'b0000;
      tick();
      tick();
      chk("rr_end_busy", {31'd0, busy}, 32'h0);

      // hold timeout
      req = 4'b0001;
      tick();
      chk("to_grant0", {28'd0, grant}, 32'h1);
      req = 4'b0011;
      repeat (7) tick();
      chk("to_hold7", {28'd0, grant}, 32'h1);
      chk("to_hold7_pre", {31'd0, preempt}, 32'h0);
      tick();
`ifdef LED_ARB_TIMEOUT_EN
      chk("to_pre_grant", {28'd0, grant}, 32'h0);
      chk("to_pre_pulse", {31'd0, preempt}, 32'h1);
      tick();
      chk("to_next_grant", {28'd0, grant}, 32'h2);
      chk("to_pre_clear", {31'd0, preempt}, 32'h0);
`else
      chk("to_keep_grant", {28'd0, grant}, 32'h1);
      chk("to_no_pulse", {31'd0, preempt}, 32'h0);
      repeat (10) tick();
      chk("to_keep_late", {28'd0, grant}, 32'h1);
      chk("to_no_pulse_late", {31'd0, preempt}, 32'h0);
`endif
      req = 4'b0000;
      tick();
      tick();

      // lone owner saturates, never preempted
      req = 4'b0001;
      saw_pre = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (preempt) saw_pre = 1'b1;
      end
      chk("sat_pre", {31'd0, saw_pre}, 32'h0);
      chk("sat_grant", {28'd0, grant}, 32'h1);
      chk("sat_led", {24'd0, led}, {24'd0, pattern[7:0]});
      req = 4'b0000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
